// File: rtl/local_history_table.sv
// local_history_table: per-branch local history shift table with a sequential flush FSM;
// define LHT_REPAIR_EN to add the rep_* repair write port.
module local_history_table #(
   parameter int ENTRIES = 16,
   parameter int HIST_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output logic [HIST_W-1:0]          rd_hist,
   input  logic                       upd_valid,
   input  logic [$clog2(ENTRIES)-1:0] upd_idx,
   input  logic                       upd_taken,
`ifdef LHT_REPAIR_EN
   input  logic                       rep_valid,
   input  logic [$clog2(ENTRIES)-1:0] rep_idx,
   input  logic [HIST_W-1:0]          rep_hist,
`endif
   input  logic                       clr_req,
   output logic                       busy,
   output logic                       clr_done
);
   localparam int IDX_W = $clog2(ENTRIES);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t            state, state_nxt;
   logic [IDX_W-1:0]  clr_ptr;
   logic [HIST_W-1:0] mem [ENTRIES];
   logic [HIST_W-1:0] shifted;
   always_comb begin
      busy      = state == CLEAR;
      clr_done  = busy && clr_ptr == IDX_W'(ENTRIES - 1);
      state_nxt = busy ? (clr_done ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
      rd_hist   = busy ? '0 : mem[rd_idx];
      // truncating cast drops the oldest bit and also covers HIST_W == 1
      shifted   = HIST_W'({mem[upd_idx], upd_taken});
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= busy ? clr_ptr + 1'b1 : '0;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      end else if (busy) begin
         mem[clr_ptr] <= '0;
      end else begin
         if (upd_valid) mem[upd_idx] <= shifted;
`ifdef LHT_REPAIR_EN
         if (rep_valid) mem[rep_idx] <= rep_hist;  // later write: repair beats a same-index shift
`endif
      end
endmodule

// File: tb/tb_local_history_table.sv
// tb_local_history_table: randomized and directed checks of local_history_table against an array model;
// exercises the repair port when LHT_REPAIR_EN is defined.
module tb_local_history_table;
   localparam int N = 16;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] rd_idx, upd_idx, rd_hist;
   logic       upd_valid, upd_taken, clr_req, busy, clr_done;
   logic       rep_valid;
   logic [3:0] rep_idx, rep_hist;
   logic [0:0] h_rd_idx, h_upd_idx, h_rd_hist;
   logic       h_upd_valid, h_upd_taken, h_clr_req, h_busy, h_clr_done;
   int         vectors = 0, miscompares = 0;
   int         model [N];

   always #5 clk = ~clk;

   local_history_table #(.ENTRIES(16), .HIST_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_hist(rd_hist),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
`ifdef LHT_REPAIR_EN
      .rep_valid(rep_valid), .rep_idx(rep_idx), .rep_hist(rep_hist),
`endif
      .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
   );

   local_history_table #(.ENTRIES(2), .HIST_W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rd_idx(h_rd_idx), .rd_hist(h_rd_hist),
      .upd_valid(h_upd_valid), .upd_idx(h_upd_idx), .upd_taken(h_upd_taken),
`ifdef LHT_REPAIR_EN
      .rep_valid(1'b0), .rep_idx(1'b0), .rep_hist(1'b0),
`endif
      .clr_req(h_clr_req), .busy(h_busy), .clr_done(h_clr_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_model(input int idx, input int t);
      model[idx] = (model[idx] * 2 + t) % 16;
   endtask

   task automatic apply_model();
      if (upd_valid) shift_model(int'(upd_idx), int'(upd_taken));
`ifdef LHT_REPAIR_EN
      if (rep_valid) model[rep_idx] = int'(rep_hist);
`endif
   endtask

   task automatic drive_upd(input int idx, input int t);
      upd_valid = 1'b1;
      upd_idx   = 4'(idx);
      upd_taken = t[0];
      tick();
      shift_model(idx, t);
      upd_valid = 1'b0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         rd_idx = 4'(i);
         #1;
         check(tag, 32'(rd_hist), 32'(model[i]));
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) model[i] = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      {rd_idx, upd_idx, upd_valid, upd_taken, clr_req} = '0;
      {rep_valid, rep_idx, rep_hist} = '0;
      {h_rd_idx, h_upd_idx, h_upd_valid, h_upd_taken, h_clr_req} = '0;
      clear_model();
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(clr_done), 32'd0);
      check("rst_rd", 32'(rd_hist), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      drive_upd(3, 1); drive_upd(3, 0); drive_upd(3, 1); drive_upd(3, 1);
      rd_idx = 4'd3;
      #1;
      check("hist3_1011", 32'(rd_hist), 32'hB);
      sweep("sweep_after_idx3");

      drive_upd(5, 1); drive_upd(5, 0); drive_upd(5, 1); drive_upd(5, 1);
      upd_valid = 1'b1; upd_idx = 4'd5; upd_taken = 1'b0; rd_idx = 4'd5;
      #1;
      check("no_bypass_1011", 32'(rd_hist), 32'hB);
      tick();
      shift_model(5, 0);
      upd_valid = 1'b0;
      #1;
      check("msb_drop_0110", 32'(rd_hist), 32'h6);

      repeat (300) begin
         rd_idx    = 4'($urandom_range(0, 15));
         upd_valid = 1'($urandom_range(0, 1));
         upd_idx   = 4'($urandom_range(0, 15));
         upd_taken = 1'($urandom_range(0, 1));
`ifdef LHT_REPAIR_EN
         rep_valid = ($urandom_range(0, 3) == 0);
         rep_idx   = ($urandom_range(0, 1) == 0) ? upd_idx : 4'($urandom_range(0, 15));
         rep_hist  = 4'($urandom_range(0, 15));
`endif
         #1;
         check("rand_rd", 32'(rd_hist), 32'(model[rd_idx]));
         tick();
         apply_model();
      end
      {upd_valid, rep_valid} = '0;
      sweep("sweep_after_random");

`ifdef LHT_REPAIR_EN
      rep_valid = 1'b1; rep_idx = 4'd2; rep_hist = 4'b0101;
      upd_valid = 1'b1; upd_idx = 4'd2; upd_taken = 1'b1;
      tick();
      {rep_valid, upd_valid} = '0;
      model[2] = 5;
      rd_idx = 4'd2;
      #1;
      check("rep_wins", 32'(rd_hist), 32'h5);
      rep_valid = 1'b1; rep_idx = 4'd2; rep_hist = 4'b1100;
      upd_valid = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
      tick();
      apply_model();
      {rep_valid, upd_valid} = '0;
      sweep("rep_and_upd_both");
`endif

      for (int i = 0; i < N; i++) drive_upd(i, 1);
      sweep("prefill");
      clr_req = 1'b1; upd_valid = 1'b1; upd_idx = 4'd4; upd_taken = 1'b1;
      tick();
      clr_req = 1'b0; upd_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         upd_valid = 1'($urandom_range(0, 1));
         upd_idx   = 4'($urandom_range(0, 15));
         upd_taken = 1'b1;
         clr_req   = 1'($urandom_range(0, 1));
         rd_idx    = 4'($urandom_range(0, 15));
`ifdef LHT_REPAIR_EN
         rep_valid = 1'b1; rep_idx = upd_idx; rep_hist = 4'hF;
`endif
         #1;
         check("flush_busy", 32'(busy), 32'd1);
         check("flush_rd_zero", 32'(rd_hist), 32'd0);
         check("flush_done", 32'(clr_done), 32'(k == N - 1));
         tick();
      end
      {upd_valid, clr_req, rep_valid} = '0;
      #1;
      check("flush_end_busy", 32'(busy), 32'd0);
      check("flush_end_done", 32'(clr_done), 32'd0);
      clear_model();
      sweep("post_flush");

      for (int i = 0; i < N; i++) drive_upd(i, 1);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (5) tick();
      check("abort_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      rd_idx = 4'd10;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(clr_done), 32'd0);
      check("abort_rd10", 32'(rd_hist), 32'd0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) begin
         tick();
         check("abort_no_done", 32'(clr_done), 32'd0);
         check("abort_idle", 32'(busy), 32'd0);
      end
      sweep("post_abort");

      h_upd_valid = 1'b1; h_upd_idx = 1'b1;
      for (int k = 0; k < 8; k++) begin
         h_upd_taken = 1'((k + int'($urandom_range(0, 1))) % 2);
         tick();
         h_rd_idx = 1'b1;
         #1;
         check("h1_last_outcome", 32'(h_rd_hist), 32'(h_upd_taken));
         h_rd_idx = 1'b0;
         #1;
         check("h1_other_zero", 32'(h_rd_hist), 32'd0);
      end
      h_upd_valid = 1'b0;
      check("h1_busy", 32'(h_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
